// File: rtl/palette_ctrl.sv
// palette_ctrl: 16-entry RGB332 colour palette with two registered video read
// ports and a CPU access port that only touches the palette outside the
// visible region (vid_active=0).
//
// Build option: define PALETTE_READBACK_EN to enable the CPU read path. When it
// is not defined, CPU reads still complete and ack normally, but cpu_rdata is
// tied to zero and no CPU-side read mux exists.
module palette_ctrl (
    input  logic       clk,
    input  logic       rst,
    // video port
    input  logic       vid_active,
    input  logic [3:0] addr1,
    input  logic [3:0] addr2,
    output logic [7:0] color1,
    output logic [7:0] color2,
    // CPU port
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    // Power-up / reset palette contents.
    function automatic logic [7:0] default_color(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'h00;
            4'd1:    c = 8'h02;
            4'd2:    c = 8'h14;
            4'd3:    c = 8'h16;
            4'd4:    c = 8'hA0;
            4'd5:    c = 8'hA2;
            4'd6:    c = 8'hA8;
            4'd7:    c = 8'hB6;
            4'd8:    c = 8'h49;
            4'd9:    c = 8'h4B;
            4'd10:   c = 8'h5D;
            4'd11:   c = 8'h5F;
            4'd12:   c = 8'hE9;
            4'd13:   c = 8'hEB;
            4'd14:   c = 8'hFD;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    state_t     state_q, state_d;
    logic       req_we_q, req_we_d;
    logic [3:0] req_addr_q, req_addr_d;
    logic [7:0] req_wdata_q, req_wdata_d;
    logic [7:0] mem_q [16];
    logic [7:0] mem_d [16];
    logic [7:0] color1_q, color1_d;
    logic [7:0] color2_q, color2_d;
    logic       mem_we;

    // CPU FSM: next state, request latching and write strobe.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        mem_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    req_we_d    = cpu_we;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Never start an access while pixels are being displayed.
                if (!vid_active) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Committed: completes even if vid_active rises now.
                mem_we  = req_we_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and latched request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= 4'd0;
            req_wdata_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every flop
            // samples the pre-edge value regardless of statement order.
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    // Palette next contents: single write port driven by the FSM.
    always_comb begin
        mem_d = mem_q;
        if (mem_we) begin
            mem_d[req_addr_q] = req_wdata_q;
        end
    end

    // Palette storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the palette is built from flops rather than a RAM macro
            // because reset must reload every entry with its default colour.
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= default_color(4'(i));
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Video read paths: read the pre-write contents, so a same-cycle write
    // shows up one cycle later.
    always_comb begin
        color1_d = mem_q[addr1];
        color2_d = mem_q[addr2];
    end

    // Registered video colours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color1_q <= 8'd0;
            color2_q <= 8'd0;
        end else begin
            color1_q <= color1_d;
            color2_q <= color2_d;
        end
    end

`ifdef PALETTE_READBACK_EN
    logic [7:0] rdata_q, rdata_d;

    // CPU read capture: only a read in ACCESS updates the held value.
    always_comb begin
        rdata_d = rdata_q;
        if (state_q == ST_ACCESS && !req_we_q) begin
            rdata_d = mem_q[req_addr_q];
        end
    end

    // Held CPU read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 8'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign cpu_rdata = rdata_q;
`else
    assign cpu_rdata = 8'h00;
`endif

    assign color1  = color1_q;
    assign color2  = color2_q;
    assign cpu_ack = (state_q == ST_ACK);
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_palette_ctrl.sv
// Directed testbench for palette_ctrl. Inputs change 1 ns after the rising
// edge and outputs are checked at that same point, well away from the edge.
module tb_palette_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       vid_active;
    logic [3:0] addr1, addr2;
    logic [7:0] color1, color2;
    logic       cpu_req, cpu_we;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] dflt [16] = '{8'h00, 8'h02, 8'h14, 8'h16, 8'hA0, 8'hA2, 8'hA8, 8'hB6,
                              8'h49, 8'h4B, 8'h5D, 8'h5F, 8'hE9, 8'hEB, 8'hFD, 8'hFF};

`ifdef PALETTE_READBACK_EN
    localparam logic [7:0] RD14_EXP = 8'hFD;
`else
    localparam logic [7:0] RD14_EXP = 8'h00;
`endif

    always #5 clk = ~clk;

    palette_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .vid_active (vid_active),
        .addr1      (addr1),
        .addr2      (addr2),
        .color1     (color1),
        .color2     (color2),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle request; FSM is in WAIT on return.
    task automatic cpu_issue(input logic we, input logic [3:0] a, input logic [7:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        cpu_req = 1'b0;
    endtask

    // Run a fixed window; lat = 1-based cycle in which ack was first seen
    // (cycle 1 is the current one), n = number of ack cycles.
    task automatic watch_ack(output int lat, output int n);
        lat = 0;
        n   = 0;
        for (int c = 1; c <= 12; c++) begin
            if (cpu_ack) begin
                n++;
                if (lat == 0) lat = c;
            end
            tick();
        end
    endtask

    initial begin
        int lat, nacks;
        rst        = 1'b1;
        vid_active = 1'b0;
        addr1      = 4'd0;
        addr2      = 4'd0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = 4'd0;
        cpu_wdata  = 8'd0;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_ack", cpu_ack, 1'b0);
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_color2", color2, 8'h00);
        rst = 1'b0;
        #1;
        check("color1_before_sample", color1, 8'h00);

        // Default palette sweep, one-cycle latency on both ports
        for (int i = 0; i < 16; i++) begin
            addr1 = 4'(i);
            addr2 = 4'(15 - i);
            tick();
            check($sformatf("sweep_c1_%0d", i), color1, dflt[i]);
            check($sformatf("sweep_c2_%0d", i), color2, dflt[15 - i]);
        end

        // Write held off by active video, then ack on 3rd inactive cycle
        vid_active = 1'b1;
        cpu_issue(1'b1, 4'd3, 8'h1C);
        for (int i = 0; i < 4; i++) begin
            check("active_busy", busy, 1'b1);
            check("active_no_ack", cpu_ack, 1'b0);
            tick();
        end
        vid_active = 1'b0;
        watch_ack(lat, nacks);
        check("wr3_ack_latency", lat, 3);
        check("wr3_ack_count", nacks, 1);
        check("wr3_idle_busy", busy, 1'b0);
        addr1 = 4'd3;
        tick();
        check("wr3_readback_video", color1, 8'h1C);

        // Same-cycle video read of the entry being written sees old value
        addr1 = 4'd5;
        cpu_issue(1'b1, 4'd5, 8'h77);   // now in WAIT
        tick();                         // now in ACCESS
        check("wr5_in_access_busy", busy, 1'b1);
        tick();                         // now in ACK
        check("wr5_old_value", color1, 8'hA2);
        check("wr5_ack", cpu_ack, 1'b1);
        tick();
        check("wr5_new_value", color1, 8'h77);
        check("wr5_ack_one_cycle", cpu_ack, 1'b0);

        // CPU read of entry 14
        cpu_issue(1'b0, 4'd14, 8'h00);
        tick();
        tick();
        check("rd14_ack", cpu_ack, 1'b1);
        check("rd14_rdata", cpu_rdata, RD14_EXP);
        tick();

        // Inputs changed during WAIT are ignored
        vid_active = 1'b1;
        cpu_issue(1'b1, 4'd7, 8'h3C);
        cpu_we    = 1'b0;
        cpu_addr  = 4'd8;
        cpu_wdata = 8'h99;
        tick();
        tick();
        vid_active = 1'b0;
        watch_ack(lat, nacks);
        check("latch_ack_latency", lat, 3);
        addr1 = 4'd7;
        addr2 = 4'd8;
        tick();
        check("latch_entry7", color1, 8'h3C);
        check("latch_entry8_untouched", color2, 8'h49);
        check("rdata_held_after_write", cpu_rdata, RD14_EXP);

        // Reset during WAIT aborts the write and restores defaults
        vid_active = 1'b1;
        cpu_issue(1'b1, 4'd0, 8'hFF);
        tick();
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_ack", cpu_ack, 1'b0);
        check("abort_rdata", cpu_rdata, 8'h00);
        tick();
        vid_active = 1'b0;
        rst        = 1'b0;
        watch_ack(lat, nacks);
        check("abort_no_ack", nacks, 0);
        addr1 = 4'd0;
        addr2 = 4'd5;
        tick();
        check("abort_entry0", color1, 8'h00);
        check("abort_entry5_default", color2, 8'hA2);
        addr1 = 4'd3;
        addr2 = 4'd7;
        tick();
        check("abort_entry3_default", color1, 8'h16);
        check("abort_entry7_default", color2, 8'hB6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
